// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream types for the window collector and the perceptron stage.
package pixel_stream_pkg;

   localparam int DEF_PX_SIZE    = 8;
   localparam int DEF_INPUT_SIZE = 5;

   typedef logic [DEF_PX_SIZE-1:0] px_t;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } window_state_e;

endpackage

// File: rtl/pixel_window_collector_if.sv
// Pixel-in / window-out stream bundle; slave is the collector, master the surrounding logic.
interface pixel_window_collector_if
   import pixel_stream_pkg::*;
#(
   parameter int INPUT_SIZE = DEF_INPUT_SIZE,
   parameter int PX_SIZE    = DEF_PX_SIZE
);

   logic                               s_valid;
   logic                               s_ready;
   logic [PX_SIZE-1:0]                 s_px;
   logic                               s_last;
   logic                               m_valid;
   logic                               m_ready;
   logic [INPUT_SIZE-1:0][PX_SIZE-1:0] m_window;
   logic                               m_last;

   modport slave (
      input  s_valid, s_px, s_last, m_ready,
      output s_ready, m_valid, m_window, m_last
   );

   modport master (
      output s_valid, s_px, s_last, m_ready,
      input  s_ready, m_valid, m_window, m_last
   );

endinterface

// File: rtl/window_shift_reg.sv
// Pixel storage: shifts toward index 0 with new data entering at DEPTH-1; clear wins over shift.
module window_shift_reg #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         shift_en,
   input  logic                         clr,
   input  logic [WIDTH-1:0]             din,
   output logic [DEPTH-1:0][WIDTH-1:0]  q
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr) begin
         data_d = '0;
      end else if (shift_en) begin
         for (int i = 0; i < DEPTH-1; i++) begin
            data_d[i] = data_q[i+1];
         end
         data_d[DEPTH-1] = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/pixel_window_collector.sv
// Sliding-window collector feeding the perceptron img_in.
// Optional PIXEL_WINDOW_ZERO_PAD_EN: emit zero-padded windows for short row tails.
//
// state  | meaning
// FILL   | fewer than INPUT_SIZE pixels of the current row held
// STREAM | window full; emits every STRIDE accepted pixels
module pixel_window_collector
   import pixel_stream_pkg::*;
#(
   parameter int INPUT_SIZE = DEF_INPUT_SIZE,
   parameter int PX_SIZE    = DEF_PX_SIZE,
   parameter int STRIDE     = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pixel_window_collector_if.slave  bus
);

   localparam int FILL_W = $clog2(INPUT_SIZE+1);
   localparam int STR_W  = $clog2(STRIDE)+1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(INPUT_SIZE);
   localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE-1);

   typedef logic [INPUT_SIZE-1:0][PX_SIZE-1:0] win_t;

   window_state_e       state_q, state_d;
   logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [STR_W-1:0]    stride_cnt_q, stride_cnt_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;
   win_t                m_window_q, m_window_d;

   win_t                sr_q;
   win_t                shifted;
   win_t                win_new;
   logic                s_ready;
   logic                accept;
   logic                row_end;
   logic [FILL_W-1:0]   fill_nxt;
   logic                full_after;
   logic [STR_W-1:0]    stride_nxt;
   logic                emit;

   assign s_ready = !m_valid_q || bus.m_ready;
   assign accept  = bus.s_valid && s_ready;
   assign row_end = accept && bus.s_last;

   window_shift_reg #(
      .DEPTH (INPUT_SIZE),
      .WIDTH (PX_SIZE)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (accept),
      .clr      (row_end),
      .din      (bus.s_px),
      .q        (sr_q)
   );

   // Window as it will look once the accepted pixel is shifted in.
   always_comb begin
      for (int i = 0; i < INPUT_SIZE-1; i++) begin
         shifted[i] = sr_q[i+1];
      end
      shifted[INPUT_SIZE-1] = bus.s_px;
   end

   always_comb begin
      fill_nxt   = (fill_cnt_q == FILL_FULL) ? FILL_FULL : fill_cnt_q + 1'b1;
      full_after = (fill_nxt == FILL_FULL);
      if (state_q == FILL) begin
         stride_nxt = '0;
      end else begin
         stride_nxt = (stride_cnt_q == STR_LAST) ? '0 : stride_cnt_q + 1'b1;
      end

      emit    = accept && full_after && (stride_nxt == '0);
      win_new = shifted;
`ifdef PIXEL_WINDOW_ZERO_PAD_EN
      // Short row: received pixels sit at the top of the register; slide them down to index 0.
      if (row_end && !full_after) begin
         emit    = 1'b1;
         win_new = shifted >> ((INPUT_SIZE - int'(fill_nxt)) * PX_SIZE);
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      stride_cnt_d = stride_cnt_q;
      if (accept) begin
         if (bus.s_last) begin
            state_d      = FILL;
            fill_cnt_d   = '0;
            stride_cnt_d = '0;
         end else begin
            fill_cnt_d   = fill_nxt;
            stride_cnt_d = full_after ? stride_nxt : '0;
            state_d      = full_after ? STREAM : FILL;
         end
      end
   end

   always_comb begin
      m_valid_d  = m_valid_q;
      m_window_d = m_window_q;
      m_last_d   = m_last_q;
      if (emit) begin
         m_valid_d  = 1'b1;
         m_window_d = win_new;
         m_last_d   = bus.s_last;
      end else if (bus.m_ready) begin
         m_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         fill_cnt_q   <= '0;
         stride_cnt_q <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         m_window_q   <= '0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         stride_cnt_q <= stride_cnt_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         m_window_q   <= m_window_d;
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.m_valid  = m_valid_q;
   assign bus.m_window = m_window_q;
   assign bus.m_last   = m_last_q;

endmodule

// File: tb/tb_pixel_window_collector.sv
// Bench for pixel_window_collector: STRIDE=1 and STRIDE=2 instances against a row-level reference model.
module tb_pixel_window_collector;
   import pixel_stream_pkg::*;

   localparam int N  = 5;
   localparam int PX = 8;

   typedef logic [N-1:0][PX-1:0] twin_t;

   logic clk;
   logic rst_n;
   logic s_valid;
   logic [PX-1:0] s_px;
   logic s_last;
   logic m_ready;

   int n_tests = 0;
   int n_fail  = 0;

   pixel_window_collector_if #(.INPUT_SIZE(N), .PX_SIZE(PX)) if1 ();
   pixel_window_collector_if #(.INPUT_SIZE(N), .PX_SIZE(PX)) if2 ();

   assign if1.s_valid = s_valid;
   assign if1.s_px    = s_px;
   assign if1.s_last  = s_last;
   assign if1.m_ready = m_ready;
   assign if2.s_valid = s_valid;
   assign if2.s_px    = s_px;
   assign if2.s_last  = s_last;
   assign if2.m_ready = m_ready;

   pixel_window_collector #(.INPUT_SIZE(N), .PX_SIZE(PX), .STRIDE(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   pixel_window_collector #(.INPUT_SIZE(N), .PX_SIZE(PX), .STRIDE(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: per-row pixel list; a window is the last N pixels of the row.
   px_t   row_q [2][$];
   twin_t exp_w [2][$];
   logic  exp_l [2][$];
   twin_t cap_w [2][$];
   logic  cap_l [2][$];
   logic  stall_p [2];
   twin_t held_w [2];
   logic  held_l [2];
   int    stride_of [2] = '{1, 2};

   task automatic model_accept(input int d, input px_t px, input logic last);
      twin_t w;
      int n;
      row_q[d].push_back(px);
      n = row_q[d].size();
      if (n >= N) begin
         if (((n - N) % stride_of[d]) == 0) begin
            for (int i = 0; i < N; i++) w[i] = row_q[d][n-N+i];
            exp_w[d].push_back(w);
            exp_l[d].push_back(last);
         end
      end else if (last) begin
`ifdef PIXEL_WINDOW_ZERO_PAD_EN
         w = '0;
         for (int i = 0; i < n; i++) w[i] = row_q[d][i];
         exp_w[d].push_back(w);
         exp_l[d].push_back(1'b1);
`endif
      end
      if (last) row_q[d].delete();
   endtask

   task automatic mon(input int d, input logic sv, input logic sr, input px_t px, input logic sl,
                      input logic mv, input logic mr, input twin_t mw, input logic ml);
      if (!rst_n) begin
         row_q[d].delete();
         exp_w[d].delete();
         exp_l[d].delete();
         stall_p[d] = 1'b0;
         return;
      end
      if (stall_p[d]) begin
         chk("hold_valid", mv, 1'b1);
         chk("hold_window", mw, held_w[d]);
         chk("hold_last", ml, held_l[d]);
      end
      if (mv && mr) begin
         chk("sb_pending", exp_w[d].size() != 0, 1'b1);
         if (exp_w[d].size() != 0) begin
            chk("sb_window", mw, exp_w[d].pop_front());
            chk("sb_last", ml, exp_l[d].pop_front());
         end
         cap_w[d].push_back(mw);
         cap_l[d].push_back(ml);
      end
      stall_p[d] = mv && !mr;
      held_w[d]  = mw;
      held_l[d]  = ml;
      if (sv && sr) model_accept(d, px, sl);
   endtask

   always @(posedge clk) mon(0, if1.s_valid, if1.s_ready, if1.s_px, if1.s_last,
                             if1.m_valid, if1.m_ready, if1.m_window, if1.m_last);
   always @(posedge clk) mon(1, if2.s_valid, if2.s_ready, if2.s_px, if2.s_last,
                             if2.m_valid, if2.m_ready, if2.m_window, if2.m_last);

   function automatic twin_t seq_win(input int s);
      twin_t w;
      for (int i = 0; i < N; i++) w[i] = PX'(s + i);
      return w;
   endfunction

   task automatic clear_caps();
      for (int d = 0; d < 2; d++) begin
         cap_w[d].delete();
         cap_l[d].delete();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one pixel and hold it until the STRIDE=1 instance takes it.
   task automatic send(input int px, input logic last);
      int cyc = 0;
      s_valid = 1'b1;
      s_px    = PX'(px);
      s_last  = last;
      @(negedge clk);
      while (!if1.s_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!if1.s_ready) chk("send_accept", if1.s_ready, 1'b1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic check_seq_caps(input string tag, input int d, input int cnt, input int first, input int step);
      chk({tag, "_count"}, cap_w[d].size(), cnt);
      for (int k = 0; k < cnt; k++) begin
         if (k < cap_w[d].size()) begin
            chk({tag, "_win"}, cap_w[d][k], seq_win(first + k*step));
            chk({tag, "_last"}, cap_l[d][k], k == cnt-1);
         end
      end
   endtask

   initial begin
      twin_t pad_w;
      int acc_n;
      int guard;
      logic acc;
      px_t cur_px;

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_px    = '0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      idle(3);
      chk("rst_m_valid", if1.m_valid, 1'b0);
      chk("rst_m_last", if1.m_last, 1'b0);
      chk("rst_m_window", if1.m_window, '0);
      rst_n = 1'b1;
      idle(1);
      chk("rst_s_ready", if1.s_ready, 1'b1);
      chk("rst_s_ready2", if2.s_ready, 1'b1);

      // Basic stream, STRIDE=1
      clear_caps();
      for (int p = 1; p <= 8; p++) begin
         send(p, p == 8);
         if (p == 4) chk("lat_before_full", if1.m_valid, 1'b0);
         if (p == 5) begin
            chk("lat_first_valid", if1.m_valid, 1'b1);
            chk("lat_first_win", if1.m_window, seq_win(1));
         end
      end
      idle(4);
      check_seq_caps("s1", 0, 4, 1, 1);

      // Stride 2 on the second instance
      clear_caps();
      for (int p = 1; p <= 9; p++) send(p, p == 9);
      idle(4);
      check_seq_caps("s2", 1, 3, 1, 2);

      // Backpressure
      clear_caps();
      m_ready = 1'b0;
      for (int p = 1; p <= 5; p++) send(p, 1'b0);
      chk("bp_valid", if1.m_valid, 1'b1);
      s_valid = 1'b1;
      s_px    = 8'd6;
      s_last  = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("bp_s_ready", if1.s_ready, 1'b0);
         chk("bp_hold", if1.m_window, seq_win(1));
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("bp_next_valid", if1.m_valid, 1'b1);
      chk("bp_next_win", if1.m_window, seq_win(2));
      send(7, 1'b1);
      idle(4);
      check_seq_caps("bp", 0, 3, 1, 1);

      // Short row then a full row
      clear_caps();
      for (int p = 1; p <= 3; p++) send(p, p == 3);
      for (int p = 10; p <= 14; p++) send(p, p == 14);
      idle(4);
`ifdef PIXEL_WINDOW_ZERO_PAD_EN
      pad_w = '0;
      pad_w[0] = 8'd1;
      pad_w[1] = 8'd2;
      pad_w[2] = 8'd3;
      chk("short_count", cap_w[0].size(), 2);
      if (cap_w[0].size() >= 2) begin
         chk("short_pad_win", cap_w[0][0], pad_w);
         chk("short_pad_last", cap_l[0][0], 1'b1);
         chk("short_next_win", cap_w[0][1], seq_win(10));
         chk("short_next_last", cap_l[0][1], 1'b1);
      end
`else
      check_seq_caps("short", 0, 1, 10, 1);
`endif

      // Asynchronous reset mid-row
      for (int p = 1; p <= 4; p++) send(p, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_m_valid", if1.m_valid, 1'b0);
      chk("arst_m_window", if1.m_window, '0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(1);
      clear_caps();
      for (int p = 20; p <= 24; p++) send(p, p == 24);
      idle(4);
      check_seq_caps("arst", 0, 1, 20, 1);

      // Random traffic with s_last every 17 accepted pixels
      acc_n  = 0;
      guard  = 0;
      cur_px = PX'($urandom_range(0, 255));
      while (acc_n < 1000 && guard < 20000) begin
         s_valid = ($urandom_range(0, 9) < 7);
         m_ready = ($urandom_range(0, 9) < 6);
         s_px    = cur_px;
         s_last  = ((acc_n + 1) % 17) == 0;
         @(negedge clk);
         acc = s_valid && if1.s_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_n++;
            cur_px = PX'($urandom_range(0, 255));
         end
         guard++;
      end
      if (acc_n < 1000) chk("rand_progress", acc_n, 1000);
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      idle(10);
      chk("drain_dut1", exp_w[0].size(), 0);
      chk("drain_dut2", exp_w[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
